// File: rtl/sif_access_arbiter_if.sv
// sif_access_arbiter_if: requester (XA, WA) and SIF slave signals of the access arbiter
interface sif_access_arbiter_if #(parameter int AW = 8, parameter int DW = 16);
  logic          xa_wr_s, xa_rd_s, xa_ack, xa_err;
  logic [AW-1:0] xa_addr;
  logic [DW-1:0] xa_wdata, xa_rdata;
  logic          wa_wr_s, wa_rd_s, wa_ack, wa_err;
  logic [AW-1:0] wa_addr;
  logic [DW-1:0] wa_wdata, wa_rdata;
  logic          sif_wr_s, sif_rd_s, sif_rvalid;
  logic [AW-1:0] sif_addr;
  logic [DW-1:0] sif_wdata, sif_rdata;
  modport master (
    output xa_wr_s, xa_rd_s, xa_addr, xa_wdata, wa_wr_s, wa_rd_s, wa_addr, wa_wdata,
           sif_rdata, sif_rvalid,
    input  xa_ack, xa_err, xa_rdata, wa_ack, wa_err, wa_rdata,
           sif_wr_s, sif_rd_s, sif_addr, sif_wdata
  );
  modport slave (
    input  xa_wr_s, xa_rd_s, xa_addr, xa_wdata, wa_wr_s, wa_rd_s, wa_addr, wa_wdata,
           sif_rdata, sif_rvalid,
    output xa_ack, xa_err, xa_rdata, wa_ack, wa_err, wa_rdata,
           sif_wr_s, sif_rd_s, sif_addr, sif_wdata
  );
endinterface

// File: rtl/sif_access_arbiter.sv
// sif_access_arbiter: round-robin sharing of one SIF port between XA and WA; read timeout under SIF_ARB_TIMEOUT_EN
module sif_access_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int TIMEOUT_CYC = 16
) (
  input logic clk,
  input logic rst,
  sif_access_arbiter_if.slave b
);
  typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, DONE} state_t;
  state_t state;
  logic last_grant, gnt;
  logic xa_ill, wa_ill, xa_req, wa_req, pick_wa, g_wr;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
`ifdef SIF_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
`endif
  // last_grant/gnt: 1 = WA, 0 = XA
  always_comb begin
    xa_ill  = b.xa_wr_s & b.xa_rd_s;
    wa_ill  = b.wa_wr_s & b.wa_rd_s;
    xa_req  = b.xa_wr_s ^ b.xa_rd_s;
    wa_req  = b.wa_wr_s ^ b.wa_rd_s;
    pick_wa = wa_req & (~xa_req | ~last_grant);
    g_wr    = pick_wa ? b.wa_wr_s : b.xa_wr_s;
    g_addr  = pick_wa ? b.wa_addr : b.xa_addr;
    g_wdata = pick_wa ? b.wa_wdata : b.xa_wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      b.xa_ack   <= 1'b0;
      b.xa_err   <= 1'b0;
      b.xa_rdata <= '0;
      b.wa_ack   <= 1'b0;
      b.wa_err   <= 1'b0;
      b.wa_rdata <= '0;
      b.sif_wr_s <= 1'b0;
      b.sif_rd_s <= 1'b0;
      b.sif_addr <= '0;
      b.sif_wdata <= '0;
`ifdef SIF_ARB_TIMEOUT_EN
      cnt <= '0;
`endif
    end else begin
      b.xa_ack   <= 1'b0;
      b.xa_err   <= 1'b0;
      b.wa_ack   <= 1'b0;
      b.wa_err   <= 1'b0;
      b.sif_wr_s <= 1'b0;
      b.sif_rd_s <= 1'b0;
      case (state)
        IDLE: begin
          // strobe and write ack are issued from the grant edge so they appear in the WR/RD cycle
          if (xa_ill | wa_ill) begin
            b.xa_ack <= xa_ill;
            b.xa_err <= xa_ill;
            b.wa_ack <= wa_ill;
            b.wa_err <= wa_ill;
            state    <= DONE;
          end else if (xa_req | wa_req) begin
            gnt        <= pick_wa;
            last_grant <= pick_wa;
            b.sif_addr <= g_addr;
            if (g_wr) begin
              b.sif_wdata <= g_wdata;
              b.sif_wr_s  <= 1'b1;
              b.xa_ack    <= ~pick_wa;
              b.wa_ack    <= pick_wa;
              state       <= WR;
            end else begin
              b.sif_rd_s <= 1'b1;
              state      <= RD;
            end
          end
        end
        WR: state <= DONE;
        RD: begin
`ifdef SIF_ARB_TIMEOUT_EN
          cnt <= '0;
`endif
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (b.sif_rvalid) begin
            b.xa_ack <= ~gnt;
            b.wa_ack <= gnt;
            if (gnt) b.wa_rdata <= b.sif_rdata;
            else b.xa_rdata <= b.sif_rdata;
            state <= DONE;
          end
`ifdef SIF_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            b.xa_ack <= ~gnt;
            b.xa_err <= ~gnt;
            b.wa_ack <= gnt;
            b.wa_err <= gnt;
            if (gnt) b.wa_rdata <= DW'(16'hDEAD);
            else b.xa_rdata <= DW'(16'hDEAD);
            state <= DONE;
          end else cnt <= cnt + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sif_access_arbiter.sv
// tb_sif_access_arbiter: directed vectors with hand-computed expectations for sif_access_arbiter
module tb_sif_access_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  sif_access_arbiter_if #(.AW(8), .DW(16)) bus ();
  sif_access_arbiter #(.AW(8), .DW(16), .TIMEOUT_CYC(16)) dut (.clk(clk), .rst(rst), .b(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic idle_inputs();
    bus.xa_wr_s = 0; bus.xa_rd_s = 0; bus.xa_addr = 0; bus.xa_wdata = 0;
    bus.wa_wr_s = 0; bus.wa_rd_s = 0; bus.wa_addr = 0; bus.wa_wdata = 0;
    bus.sif_rvalid = 0; bus.sif_rdata = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    cyc(2);
    rst = 0;
  endtask
  initial begin
    int xa_n, wa_n, k, early;
    logic exp_wa;
    idle_inputs();
    do_reset();
    chk("rst_sif_wr", bus.sif_wr_s, 0);
    chk("rst_sif_rd", bus.sif_rd_s, 0);
    chk("rst_sif_addr", bus.sif_addr, 0);
    chk("rst_sif_wdata", bus.sif_wdata, 0);
    chk("rst_acks", {bus.xa_ack, bus.xa_err, bus.wa_ack, bus.wa_err}, 0);
    chk("rst_rdata", {bus.xa_rdata, bus.wa_rdata}, 0);
    // XA write
    bus.xa_wr_s = 1; bus.xa_addr = 8'h10; bus.xa_wdata = 16'hA5A5;
    cyc();
    chk("wr_strobe", bus.sif_wr_s, 1);
    chk("wr_addr", bus.sif_addr, 8'h10);
    chk("wr_data", bus.sif_wdata, 16'hA5A5);
    chk("wr_ack", {bus.xa_ack, bus.xa_err, bus.wa_ack}, 3'b100);
    bus.xa_wr_s = 0;
    cyc();
    chk("wr_pulse_end", {bus.sif_wr_s, bus.xa_ack}, 0);
    cyc();
    // simultaneous reads after reset: XA first, then WA
    do_reset();
    bus.xa_rd_s = 1; bus.xa_addr = 8'h20;
    bus.wa_rd_s = 1; bus.wa_addr = 8'h30;
    cyc();
    chk("rd1_strobe", {bus.sif_rd_s, bus.sif_wr_s}, 2'b10);
    chk("rd1_addr", bus.sif_addr, 8'h20);
    cyc();
    chk("rd1_strobe_end", bus.sif_rd_s, 0);
    bus.sif_rvalid = 1; bus.sif_rdata = 16'h1234;
    cyc();
    bus.sif_rvalid = 0;
    chk("rd1_ack", {bus.xa_ack, bus.xa_err, bus.wa_ack}, 3'b100);
    chk("rd1_xa_rdata", bus.xa_rdata, 16'h1234);
    bus.xa_rd_s = 0;
    cyc(2);
    chk("rd2_strobe", bus.sif_rd_s, 1);
    chk("rd2_addr", bus.sif_addr, 8'h30);
    bus.sif_rvalid = 1; bus.sif_rdata = 16'hBAD1;
    cyc();
    bus.sif_rvalid = 0;
    chk("rd2_same_cycle_rvalid_ignored", bus.wa_ack, 0);
    cyc();
    chk("rd2_still_waiting", bus.wa_ack, 0);
    bus.sif_rvalid = 1; bus.sif_rdata = 16'h5678;
    cyc();
    bus.sif_rvalid = 0;
    chk("rd2_ack", {bus.wa_ack, bus.wa_err, bus.xa_ack}, 3'b100);
    chk("rd2_wa_rdata", bus.wa_rdata, 16'h5678);
    chk("rd2_xa_rdata_held", bus.xa_rdata, 16'h1234);
    bus.wa_rd_s = 0;
    cyc(2);
    // WA illegal request
    bus.wa_wr_s = 1; bus.wa_rd_s = 1;
    cyc();
    chk("ill_ack", {bus.wa_ack, bus.wa_err, bus.xa_ack}, 3'b110);
    chk("ill_no_strobe", {bus.sif_wr_s, bus.sif_rd_s}, 0);
    bus.wa_wr_s = 0; bus.wa_rd_s = 0;
    cyc(2);
    chk("ill_quiet", {bus.wa_ack, bus.wa_err}, 0);
    // continuous contention: 6 writes alternating from XA
    bus.xa_wr_s = 1; bus.xa_addr = 8'h40; bus.xa_wdata = 16'h1111;
    bus.wa_wr_s = 1; bus.wa_addr = 8'h50; bus.wa_wdata = 16'h2222;
    xa_n = 0; wa_n = 0; k = 0;
    for (int c = 0; c < 16; c++) begin
      cyc();
      if (bus.xa_ack | bus.wa_ack) begin
        exp_wa = k[0];
        chk($sformatf("rr_order_%0d", k), {bus.xa_ack, bus.wa_ack}, exp_wa ? 2'b01 : 2'b10);
        chk($sformatf("rr_addr_%0d", k), bus.sif_addr, exp_wa ? 8'h50 : 8'h40);
        xa_n += int'(bus.xa_ack);
        wa_n += int'(bus.wa_ack);
        k++;
      end
    end
    bus.xa_wr_s = 0; bus.wa_wr_s = 0;
    cyc(3);
    chk("rr_xa_count", xa_n, 3);
    chk("rr_wa_count", wa_n, 3);
    // reset during RD_WAIT
    bus.xa_rd_s = 1; bus.xa_addr = 8'h60;
    cyc(3);
    rst = 1;
    cyc();
    rst = 0;
    bus.xa_rd_s = 0;
    chk("mid_rst_outputs", {bus.sif_wr_s, bus.sif_rd_s, bus.xa_ack, bus.wa_ack, bus.xa_err, bus.wa_err}, 0);
    chk("mid_rst_bus", {bus.sif_addr, bus.sif_wdata}, 0);
    chk("mid_rst_rdata", {bus.xa_rdata, bus.wa_rdata}, 0);
    bus.sif_rvalid = 1; bus.sif_rdata = 16'h9999;
    cyc();
    bus.sif_rvalid = 0;
    chk("late_rvalid_no_ack", {bus.xa_ack, bus.wa_ack}, 0);
    chk("late_rvalid_rdata", bus.xa_rdata, 0);
    bus.xa_wr_s = 1; bus.xa_addr = 8'h70; bus.xa_wdata = 16'hBEEF;
    cyc();
    chk("post_rst_wr", {bus.sif_wr_s, bus.xa_ack, bus.xa_err}, 3'b110);
    chk("post_rst_bus", {bus.sif_addr, bus.sif_wdata}, {8'h70, 16'hBEEF});
    bus.xa_wr_s = 0;
    cyc(2);
`ifdef SIF_ARB_TIMEOUT_EN
    bus.xa_rd_s = 1; bus.xa_addr = 8'h80;
    cyc(2);
    early = 0;
    for (int c = 0; c < 15; c++) begin
      cyc();
      early += int'(bus.xa_ack);
    end
    chk("to_no_early_ack", early, 0);
    cyc();
    chk("to_ack_err", {bus.xa_ack, bus.xa_err}, 2'b11);
    chk("to_rdata", bus.xa_rdata, 16'hDEAD);
    bus.xa_rd_s = 0;
    bus.sif_rvalid = 1; bus.sif_rdata = 16'h4444;
    cyc();
    bus.sif_rvalid = 0;
    chk("to_late_rvalid", {bus.xa_ack, bus.xa_rdata}, {1'b0, 16'hDEAD});
    cyc(2);
`else
    early = 0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
